// File: rtl/img_pkg.sv
// Shared definitions for the edge-stream framing path: frame FSM states and
// the side-band flag layout that travels with each pixel.
package img_pkg;

    typedef enum logic {
        ST_SOF    = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_t;

    localparam int PIX_W     = 8;
    localparam int FLAG_SOF  = 0;
    localparam int FLAG_LAST = 1;
    localparam int FLAG_EOF  = 2;
    localparam int FLAG_W    = 3;
    localparam int BEAT_W    = PIX_W + FLAG_W;

endpackage

// File: rtl/axis_skid.sv
// Output register plus one-entry skid register with ready/valid on both sides.
// The upstream ready is a register, so i_ready never reaches o_ready combinationally.
module axis_skid #(
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_xfer;
    logic             out_free;

    assign in_xfer  = i_valid && o_ready;
    assign out_free = !o_valid || i_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            skid_valid <= 1'b0;
            o_ready    <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    o_valid    <= 1'b1;
                    o_data     <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    o_valid <= in_xfer;
                    if (in_xfer) begin
                        o_data <= i_data;
                    end
                end
            end else if (in_xfer) begin
                skid_valid <= 1'b1;
            end
            // Ready for next cycle is simply "skid will be empty".
            o_ready <= out_free || !(skid_valid || in_xfer);
        end
    end

    // NOTE: skid payload has no reset; skid_valid alone decides whether it is meaningful.
    always_ff @(posedge i_clk) begin
        if (!out_free && in_xfer) begin
            skid_data <= i_data;
        end
    end

endmodule

// File: rtl/edge_stream_framer.sv
// Binarises an edge-magnitude pixel stream against a per-frame threshold, tags
// SOF/EOL, and reports the edge-pixel count of each completed frame.
module edge_stream_framer
    import img_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int CNT_W = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data_valid,
    input  logic [7:0]       i_data,
    output logic             o_data_ready,
    input  logic [7:0]       i_threshold,
    output logic             o_data_valid,
    output logic [7:0]       o_data,
    output logic             o_data_last,
    output logic             o_data_user,
    input  logic             i_data_ready,
    output logic [CNT_W-1:0] o_edge_count,
    output logic             o_frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    frame_state_t      state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [7:0]        thr_q;
    logic [7:0]        thr_eff;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              in_xfer;
    logic              is_edge;
    logic              line_end;
    logic              frame_end;
    logic [BEAT_W-1:0] beat_in;
    logic [BEAT_W-1:0] beat_out;

    assign in_xfer = i_data_valid && o_data_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        beat_in   = '0;
        thr_eff   = (state == ST_SOF) ? i_threshold : thr_q;
        is_edge   = (i_data >= thr_eff);
        line_end  = (col == COL_W'(IMG_W - 1));
        frame_end = line_end && (row == ROW_W'(IMG_H - 1));
        cnt_next  = (is_edge && (run_cnt != '1)) ? run_cnt + CNT_W'(1) : run_cnt;
        beat_in[BEAT_W-1:FLAG_W] = is_edge ? 8'hFF : 8'h00;
        beat_in[FLAG_SOF]        = (state == ST_SOF);
        beat_in[FLAG_LAST]       = line_end;
        beat_in[FLAG_EOF]        = frame_end;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_SOF;
            col          <= '0;
            row          <= '0;
            thr_q        <= '0;
            run_cnt      <= '0;
            o_edge_count <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= o_data_valid && i_data_ready && beat_out[FLAG_EOF];
            if (in_xfer) begin
                if (state == ST_SOF) begin
                    thr_q <= i_threshold;
                end
                if (frame_end) begin
                    state        <= ST_SOF;
                    col          <= '0;
                    row          <= '0;
                    run_cnt      <= '0;
                    o_edge_count <= cnt_next;
                end else begin
                    state   <= ST_ACTIVE;
                    run_cnt <= cnt_next;
                    if (line_end) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end
        end
    end

    axis_skid #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_data_valid),
        .o_ready (o_data_ready),
        .i_data  (beat_in),
        .o_valid (o_data_valid),
        .i_ready (i_data_ready),
        .o_data  (beat_out)
    );

    assign o_data      = beat_out[BEAT_W-1:FLAG_W];
    assign o_data_last = beat_out[FLAG_LAST];
    assign o_data_user = beat_out[FLAG_SOF];

endmodule

// File: doc/edge_stream_framer.md
EDGE_STREAM_FRAMER -- requirements
Module: edge_stream_framer

Interface
REQ-001 Parameter IMG_W, default 512, pixels per line.
REQ-002 Parameter IMG_H, default 512, lines per frame.
REQ-003 Parameter CNT_W, default $clog2(IMG_W*IMG_H+1), edge-count width.
REQ-004 i_clk  in  1  single clock; all logic rising-edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_data_valid  in  1  upstream pixel valid (conv output FIFO master).
REQ-007 i_data  in  8  edge-magnitude pixel.
REQ-008 o_data_ready  out  1  upstream may transfer.
REQ-009 i_threshold  in  8  binarisation threshold.
REQ-010 o_data_valid  out  1  binarised pixel valid.
REQ-011 o_data  out  8  binarised pixel.
REQ-012 o_data_last  out  1  last pixel of line (TLAST).
REQ-013 o_data_user  out  1  first pixel of frame (TUSER/SOF).
REQ-014 i_data_ready  in  1  downstream accepts.
REQ-015 o_edge_count  out  CNT_W  edge pixels in last completed frame.
REQ-016 o_frame_done  out  1  one-cycle pulse per completed frame.

Function
REQ-017 Input transfer occurs when i_data_valid && o_data_ready; output transfer when o_data_valid && i_data_ready.
REQ-018 Datapath: output register plus one-entry skid register; o_data_ready = skid empty (registered, no combinational path from i_data_ready).
REQ-019 Latency: pixel accepted at cycle N appears on o_data at N+1 when output register free or draining.
REQ-020 When output stalls and a pixel arrives, it is stored in skid; skid drains into output register on next output transfer; order preserved, no drop, no duplicate.
REQ-021 o_data, o_data_last, o_data_user held stable while o_data_valid && !i_data_ready.
REQ-022 o_data = 8'hFF if pixel >= threshold in effect, else 8'h00 (unsigned compare).
REQ-023 Threshold latched from i_threshold on acceptance of a frame's first pixel; constant for rest of frame.
REQ-024 FSM states SOF, ACTIVE; SOF -> ACTIVE on first input transfer; ACTIVE -> SOF on input transfer with col=IMG_W-1 and row=IMG_H-1.
REQ-025 Column counter 0..IMG_W-1, row counter 0..IMG_H-1, advance on input transfer only; col wraps to 0 and row increments at col=IMG_W-1; both wrap to 0 at frame end.
REQ-026 SOF flag set for pixel accepted in SOF state (first pixel, latched threshold applied); last flag set at col=IMG_W-1; eof flag (internal) at frame end; flags travel with pixel through skid/output registers.
REQ-027 Running count increments per accepted pixel >= threshold; saturates at 2^CNT_W-1; cleared when frame's final pixel is accepted, after its contribution is added.
REQ-028 o_edge_count updated with final frame count (including final pixel) in the cycle the eof pixel is accepted; holds until next frame end.
REQ-029 o_frame_done pulses one cycle on output transfer of the eof-flagged pixel.
REQ-030 Back-to-back frames: first pixel of frame k+1 accepted in the cycle after frame k's eof with no bubble.

Reset
REQ-031 On i_rst: o_data_valid=0, o_data=0, o_data_last=0, o_data_user=0, o_frame_done=0, o_edge_count=0, o_data_ready=0 during reset and 1 first cycle after, skid empty, counters 0, FSM=SOF, latched threshold 0.
REQ-032 Reset mid-frame discards partial frame, in-flight pixels and running count; next accepted pixel is SOF.

Structure
REQ-033 FSM state enum and flag bit positions in shared package img_pkg.
REQ-034 Skid buffer as sub-module axis_skid (8-bit data + 3 flag bits, ready/valid both sides).

Verification (IMG_W=4, IMG_H=3)
REQ-035 Threshold 100, stream 0,99,100,255 repeated, ready=1 -> outputs 00,00,FF,FF each line, latency 1, last on every 4th, user on 1st only, o_edge_count=6, one frame_done.
REQ-036 i_data_ready low 5 cycles mid-line with valid held -> o_data_ready drops after one skid entry, no loss/duplicate, output order equals input.
REQ-037 i_threshold changed 50->200 mid-frame -> frame uses 50; next frame's pixel 150 gives 00.
REQ-038 Two frames back-to-back, all 255, threshold 0 -> o_edge_count=12 after each, two frame_done pulses, user on pixels 0 and 12.
REQ-039 i_rst asserted after 5 pixels -> all outputs reset; next pixel gets user=1, count restarts from 0.
REQ-040 Random valid/ready (50% each), 20 frames -> scoreboard match of data, last, user, counts.
